// File: rtl/uart_tx_fifo_if.sv
// Producer-side bundle for uart_tx_fifo: write port, frame configuration and
// status/serial outputs.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic [DIV_WIDTH-1:0] baud_div;
  logic [1:0]           parity_mode;
  logic                 two_stop;
  logic                 fifo_full;
  logic [CNT_W-1:0]     fifo_count;
  logic                 overflow;
  logic                 busy;
  logic                 tx_out;
  logic                 tx_complete;

  modport master (
    output wr_en, wr_data, baud_div, parity_mode, two_stop,
    input  fifo_full, fifo_count, overflow, busy, tx_out, tx_complete
  );

  modport slave (
    input  wr_en, wr_data, baud_div, parity_mode, two_stop,
    output fifo_full, fifo_count, overflow, busy, tx_out, tx_complete
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frame format and baud divisor are
// captured per frame so frames stream back-to-back without idle gaps.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic          sourceClk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 overflow_q;
  logic                 push, pop, full, empty;
  logic [DATA_BITS-1:0] head;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bits_left_q, bits_left_d;
  logic [DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 two_stop_q, two_stop_d;
  logic                 stop_left_q, stop_left_d;
  logic                 tx_q, tx_d;
  logic                 bit_end, start_frame;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = bus.wr_en && !full;
  assign head    = mem_q[rd_ptr_q];
  assign bit_end = (baud_cnt_q == '0);

  // Storage carries no reset; the count alone decides which entries are valid.
  always_ff @(posedge sourceClk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge sourceClk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= bus.wr_en && full;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge sourceClk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bits_left_q <= '0;
      baud_cnt_q  <= '0;
      div_q       <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      two_stop_q  <= 1'b0;
      stop_left_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      baud_cnt_q  <= baud_cnt_d;
      div_q       <= div_d;
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
      two_stop_q  <= two_stop_d;
      stop_left_q <= stop_left_d;
      tx_q        <= tx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    baud_cnt_d  = bit_end ? div_q : baud_cnt_q - DIV_WIDTH'(1);
    div_d       = div_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    two_stop_d  = two_stop_q;
    stop_left_d = stop_left_q;
    tx_d        = tx_q;
    start_frame = 1'b0;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) start_frame = 1'b1;
      end
      START: begin
        if (bit_end) begin
          tx_d        = shift_q[0];
          shift_d     = shift_q >> 1;
          bits_left_d = IDX_W'(DATA_BITS - 1);
          state_d     = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bits_left_q != '0) begin
            tx_d        = shift_q[0];
            shift_d     = shift_q >> 1;
            bits_left_d = bits_left_q - IDX_W'(1);
          end else if (par_en_q) begin
            tx_d    = par_bit_q;
            state_d = PARITY;
          end else begin
            tx_d        = 1'b1;
            stop_left_d = two_stop_q;
            state_d     = STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_d        = 1'b1;
          stop_left_d = two_stop_q;
          state_d     = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_left_q)  stop_left_d = 1'b0;
          else if (!empty)  start_frame = 1'b1;
          else              state_d     = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    // Popping a word also snapshots the line format for the whole frame.
    if (start_frame) begin
      pop        = 1'b1;
      shift_d    = head;
      div_d      = bus.baud_div;
      baud_cnt_d = bus.baud_div;
      par_en_d   = (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
      par_bit_d  = (^head) ^ (bus.parity_mode == 2'b10);
      two_stop_d = bus.two_stop;
      tx_d       = 1'b0;
      state_d    = START;
    end
  end

  always_comb begin
    bus.busy        = (state_q != IDLE);
    bus.tx_complete = (state_q == STOP) && bit_end && !stop_left_q;
  end

  assign bus.tx_out     = tx_q;
  assign bus.fifo_full  = full;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
endmodule
